// File: rtl/wb_slave_mem.sv
// Wishbone classic slave backed by a DEPTH x 32-bit register memory.
// Terminates each request after WAIT_CYCLES wait states with a one-cycle ack or err pulse.
module wb_slave_mem #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [15:0] txn_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        we_q, we_d;
  logic [29:0] wadr_q, wadr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdat_q, rdat_d;
  logic [15:0] txn_count_q, txn_count_d;
  logic [31:0] mem_q [DEPTH];

  logic          req;
  logic          resp_entry;
  logic          eff_we;
  logic [29:0]   eff_wadr;
  logic [31:0]   eff_dat;
  logic [AW-1:0] eff_idx;
  logic          in_range;
  logic          mem_we;
  logic          unused_adr_bits;

  assign req             = wb_cyc_i & wb_stb_i;
  assign unused_adr_bits = ^wb_adr_i[1:0];

  // With zero wait states the response is produced on the sampling edge, so
  // the request fields come straight from the bus instead of the latches.
  always_comb begin
    if (state_q == S_IDLE) begin
      eff_we   = wb_we_i;
      eff_wadr = wb_adr_i[31:2];
      eff_dat  = wb_dat_i;
    end else begin
      eff_we   = we_q;
      eff_wadr = wadr_q;
      eff_dat  = wdat_q;
    end
  end

  assign eff_idx    = eff_wadr[AW-1:0];
  assign in_range   = (eff_wadr[29:AW] == '0);
  assign resp_entry = (state_d == S_RESP) && (state_q != S_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_d    = S_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        // A dropped request abandons the transfer silently.
        if (!req) begin
          state_d    = S_IDLE;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_d        = we_q;
    wadr_d      = wadr_q;
    wdat_d      = wdat_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdat_d      = rdat_q;
    txn_count_d = txn_count_q;
    mem_we      = 1'b0;
    if (state_q == S_IDLE && req) begin
      we_d   = wb_we_i;
      wadr_d = wb_adr_i[31:2];
      wdat_d = wb_dat_i;
    end
    if (resp_entry) begin
      if (in_range) begin
        ack_d       = 1'b1;
        txn_count_d = txn_count_q + 16'd1;
        if (eff_we) begin
          mem_we = 1'b1;
        end else begin
          rdat_d = mem_q[eff_idx];
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q        <= 1'b0;
      wadr_q      <= '0;
      wdat_q      <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdat_q      <= '0;
      txn_count_q <= '0;
    end else begin
      we_q        <= we_d;
      wadr_q      <= wadr_d;
      wdat_q      <= wdat_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdat_q      <= rdat_d;
      txn_count_q <= txn_count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[eff_idx] <= eff_dat;
    end
  end

  assign wb_dat_o  = rdat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem (DEPTH=16, WAIT_CYCLES=1): vector table plus
// hand sequences for abort, back-to-back, asynchronous reset and counter wrap.
module tb_wb_slave_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [15:0] txn_count;

  int n_total = 0;
  int n_pass  = 0;

  wb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_rdat;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    else n_pass++;
  endtask

  // Issue one request, wait (bounded) for its termination, then confirm the
  // termination pulse is gone one cycle later.
  task automatic txn(input int idx, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     output logic ack_seen, output logic err_seen, output int lat);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    ack_seen = 1'b0; err_seen = 1'b0; lat = 0;
    for (int i = 0; i < 10 && !(ack_seen || err_seen); i++) begin
      @(posedge clk); #1;
      lat++;
      ack_seen = wb_ack_o;
      err_seen = wb_err_o;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    check("pulse_width", idx, {30'd0, wb_ack_o, wb_err_o}, 32'd0);
  endtask

  task automatic txn_check(input int idx, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic e_ack, input logic e_err, input logic [31:0] e_rdat, input logic [15:0] e_cnt);
    logic a, e;
    int   lat;
    txn(idx, we, adr, dat, a, e, lat);
    check("ack", idx, {31'd0, a}, {31'd0, e_ack});
    check("err", idx, {31'd0, e}, {31'd0, e_err});
    check("latency", idx, lat, 32'd2);
    check("rdata", idx, wb_dat_o, e_rdat);
    check("txn_count", idx, {16'd0, txn_count}, {16'd0, e_cnt});
  endtask

  initial begin
    int acks, errs, consec;
    logic prev;

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,          1'b1, 1'b0, 32'h0000_0000, 16'd1};
    vecs[1]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF,  1'b1, 1'b0, 32'h0000_0000, 16'd2};
    vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,          1'b1, 1'b0, 32'hDEAD_BEEF, 16'd3};
    vecs[3]  = '{1'b1, 32'h0000_0040, 32'h1234_5678,  1'b0, 1'b1, 32'hDEAD_BEEF, 16'd3};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,          1'b1, 1'b0, 32'h0000_0000, 16'd4};
    vecs[5]  = '{1'b1, 32'h0000_000B, 32'h1111_1111,  1'b1, 1'b0, 32'h0000_0000, 16'd5};
    vecs[6]  = '{1'b0, 32'h0000_0008, 32'h0,          1'b1, 1'b0, 32'h1111_1111, 16'd6};
    vecs[7]  = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D,  1'b1, 1'b0, 32'h1111_1111, 16'd7};
    vecs[8]  = '{1'b0, 32'h0000_003C, 32'h0,          1'b1, 1'b0, 32'hCAFE_F00D, 16'd8};
    vecs[9]  = '{1'b0, 32'h0000_0040, 32'h0,          1'b0, 1'b1, 32'hCAFE_F00D, 16'd8};
    vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          1'b0, 1'b1, 32'hCAFE_F00D, 16'd8};
    vecs[11] = '{1'b0, 32'h1000_0008, 32'h0,          1'b0, 1'b1, 32'hCAFE_F00D, 16'd8};

    #12;
    check("rst_ack", 0, {31'd0, wb_ack_o}, 32'd0);
    check("rst_err", 0, {31'd0, wb_err_o}, 32'd0);
    check("rst_dat", 0, wb_dat_o, 32'd0);
    check("rst_cnt", 0, {16'd0, txn_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      txn_check(i, vecs[i].we, vecs[i].adr, vecs[i].dat,
                vecs[i].exp_ack, vecs[i].exp_err, vecs[i].exp_rdat, vecs[i].exp_cnt);

    // Strobe dropped during WAIT: no termination, no write.
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h4; wb_dat_i = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    wb_stb_i = 1'b0;
    acks = 0; errs = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (wb_ack_o) acks++;
      if (wb_err_o) errs++;
    end
    wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    check("abort_ack", 0, acks, 32'd0);
    check("abort_err", 0, errs, 32'd0);
    check("abort_cnt", 0, {16'd0, txn_count}, 32'd8);
    txn_check(20, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0, 16'd9);

    // Request held continuously: terminations every third edge.
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h8;
    acks = 0; errs = 0; consec = 0; prev = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        acks++;
        if (prev) consec++;
      end
      if (wb_err_o) errs++;
      prev = wb_ack_o;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    check("b2b_acks", 0, acks, 32'd3);
    check("b2b_consec", 0, consec, 32'd0);
    check("b2b_errs", 0, errs, 32'd0);
    check("b2b_cnt", 0, {16'd0, txn_count}, 32'd12);
    check("b2b_dat", 0, wb_dat_o, 32'h1111_1111);

    // Asynchronous reset between edges while a write is waiting.
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'hC; wb_dat_i = 32'h7777_7777;
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("arst_ack", 0, {31'd0, wb_ack_o}, 32'd0);
    check("arst_err", 0, {31'd0, wb_err_o}, 32'd0);
    check("arst_dat", 0, wb_dat_o, 32'd0);
    check("arst_cnt", 0, {16'd0, txn_count}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    #1;
    rst = 1'b1;
    txn_check(30, 1'b0, 32'hC, 32'h0, 1'b1, 1'b0, 32'h0, 16'd1);
    txn_check(31, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h0, 16'd2);

    // Counter wrap: preload near the top, then two acked reads.
    @(negedge clk);
    force dut.txn_count_q = 16'hFFFE;
    #1;
    release dut.txn_count_q;
    txn_check(40, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 16'hFFFF);
    txn_check(41, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 16'h0000);
    txn_check(42, 1'b1, 32'h80, 32'h1, 1'b0, 1'b1, 32'h0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_slave_mem.md
WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, number of 32-bit memory words (power of two, 2..256).
REQ-002 SHALL provide parameter WAIT_CYCLES, default 1, wait states inserted before ack (0..15).
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port wb_cyc_i  input  1  bus cycle valid from master.
REQ-006 SHALL provide port wb_stb_i  input  1  strobe, request valid.
REQ-007 SHALL provide port wb_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL provide port wb_adr_i  input  32  byte address.
REQ-009 SHALL provide port wb_dat_i  input  32  write data from master.
REQ-010 SHALL provide port wb_dat_o  output  32  registered read data to master.
REQ-011 SHALL provide port wb_ack_o  output  1  registered normal termination.
REQ-012 SHALL provide port wb_err_o  output  1  registered error termination.
REQ-013 SHALL provide port txn_count  output  16  count of acked transactions.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 IDLE: on edge sampling wb_cyc_i=1 and wb_stb_i=1 SHALL latch wb_we_i, wb_adr_i, wb_dat_i; go WAIT if WAIT_CYCLES>0, else RESP.
REQ-016 WAIT: SHALL count WAIT_CYCLES edges in WAIT, then go RESP; counter reloads on each entry.
REQ-017 WAIT: if wb_cyc_i=0 or wb_stb_i=0 at any edge, SHALL return to IDLE, no write, no ack/err, no count change.
REQ-018 RESP entry edge SHALL raise exactly one of wb_ack_o or wb_err_o for exactly one cycle; RESP -> IDLE unconditionally.
REQ-019 Latency: request sampled at edge E0 -> termination high during cycle after edge E0+WAIT_CYCLES (WAIT_CYCLES=0: one cycle).
REQ-020 Word index SHALL be latched wb_adr_i[log2(DEPTH)+1:2]; bits [1:0] ignored.
REQ-021 Latched address >= DEPTH*4 SHALL produce wb_err_o (not wb_ack_o), no memory write, wb_dat_o unchanged.
REQ-022 In-range write SHALL update memory at the edge raising wb_ack_o; wb_dat_o unchanged.
REQ-023 In-range read SHALL load wb_dat_o at the edge raising wb_ack_o; wb_dat_o held until next in-range read or reset.
REQ-024 Read of a word written in the immediately preceding transaction SHALL return the new value.
REQ-025 txn_count SHALL increment by 1 on each wb_ack_o (not wb_err_o); wraps 0xFFFF -> 0x0000.
REQ-026 Request still asserted in IDLE after RESP SHALL start a new transaction (back-to-back), min one IDLE cycle between terminations.
REQ-027 wb_cyc_i=1 with wb_stb_i=0 in IDLE SHALL be ignored.

Reset
REQ-028 rst=0 SHALL immediately, independent of clk: state IDLE, wait counter 0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, txn_count=0, all memory words 0.
REQ-029 Reset asserted mid-transaction SHALL abort it without write or termination; first request after rst=1 handled normally.

Verification
REQ-030 Reset, then read adr 0x00 -> wb_ack_o pulse, wb_dat_o=0x00000000, txn_count=1.
REQ-031 WAIT_CYCLES=1: write 0xDEADBEEF to adr 0x08, then read 0x08 -> ack one cycle after E0+1 each, wb_dat_o=0xDEADBEEF, txn_count=2.
REQ-032 DEPTH=16: write 0x12345678 to adr 0x40 -> wb_err_o pulse, no ack, txn_count unchanged, read of 0x00 still 0.
REQ-033 Drop wb_stb_i during WAIT on write 0xA5A5A5A5 to 0x04 -> no ack/err, later read 0x04 returns 0.
REQ-034 Assert rst=0 between clk edges during WAIT -> outputs clear immediately, memory 0; next read acks normally.
REQ-035 Force 65536 acked transactions -> txn_count wraps to 0x0000.
